gpio_irq: RTL and testbench

Parametrised memory-mapped GPIO controller and successor to the fixed 4-pin output-only GPIO. It provides a NUM_PINS-wide port with per-pin direction and a synchronised input path. It also adds per-pin rising/falling edge interrupts with write-1-to-clear status, and atomic set/clear of output bits. It sits on the core's peripheral bus with the same write-port / registered-read-address interface as the other perips.

---
 rtl/gpio_irq_if.sv | 18 +
 rtl/gpio_irq.sv | 102 ++++++++++
 tb/tb_gpio_irq.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_irq_if.sv
// rtl/gpio_irq_if.sv - peripheral bus port: write strobe/address/data and registered-address read
interface gpio_irq_if;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] rd_addr_i;
  logic [31:0] rd_data_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
    input  rd_data_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
    output rd_data_o
  );
endinterface

// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - GPIO with per-pin direction, synchronised inputs, edge interrupts and atomic set/clear
module gpio_irq #(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit OUT_INVERT  = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  gpio_irq_if.slave           bus,
  input  logic [NUM_PINS-1:0] gpio_i,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq_o
);

  localparam logic [4:0] A_DIR    = 5'h00;
  localparam logic [4:0] A_OUT    = 5'h04;
  localparam logic [4:0] A_IN     = 5'h08;
  localparam logic [4:0] A_RISE   = 5'h0C;
  localparam logic [4:0] A_FALL   = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;
  localparam logic [4:0] A_SET    = 5'h18;
  localparam logic [4:0] A_CLR    = 5'h1C;

  logic [NUM_PINS-1:0] r_dir;
  logic [NUM_PINS-1:0] r_out;
  logic [NUM_PINS-1:0] r_rise_en;
  logic [NUM_PINS-1:0] r_fall_en;
  logic [NUM_PINS-1:0] r_status;
  logic [NUM_PINS-1:0] r_prev;
  logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];
  logic [4:0]          r_rd_addr;

  logic [4:0]          w_wr_off;
  logic [NUM_PINS-1:0] w_wdata;
  logic [NUM_PINS-1:0] w_sync_q;
  logic [NUM_PINS-1:0] w_event;
  logic [NUM_PINS-1:0] w_w1c;
  logic [NUM_PINS-1:0] w_rd_sel;
  logic [31:0]         w_rd_data;
  logic                w_unused;

  assign w_wr_off = bus.wr_addr_i[4:0];
  assign w_wdata  = bus.wr_data_i[NUM_PINS-1:0];
  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_event  = (w_sync_q & ~r_prev & r_rise_en) | (~w_sync_q & r_prev & r_fall_en);
  assign w_w1c    = (bus.wr_en_i && (w_wr_off == A_STATUS)) ? w_wdata : '0;
  // Only address bits [4:0] and data bits [NUM_PINS-1:0] are decoded.
  assign w_unused = ^{bus.wr_addr_i, bus.wr_data_i, bus.rd_addr_i};

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_dir     <= '0;
      r_out     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
      r_prev    <= '0;
      r_rd_addr <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev    <= w_sync_q;
      // A new edge on a bit being cleared in the same cycle keeps the bit set.
      r_status  <= (r_status & ~w_w1c) | w_event;
      r_rd_addr <= bus.rd_addr_i[4:0];
      if (bus.wr_en_i) begin
        case (w_wr_off)
          A_DIR:   r_dir     <= w_wdata;
          A_OUT:   r_out     <= w_wdata;
          A_RISE:  r_rise_en <= w_wdata;
          A_FALL:  r_fall_en <= w_wdata;
          A_SET:   r_out     <= r_out | w_wdata;
          A_CLR:   r_out     <= r_out & ~w_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_sel = '0;
    case (r_rd_addr)
      A_DIR:    w_rd_sel = r_dir;
      A_OUT:    w_rd_sel = r_out;
      A_IN:     w_rd_sel = w_sync_q;
      A_RISE:   w_rd_sel = r_rise_en;
      A_FALL:   w_rd_sel = r_fall_en;
      A_STATUS: w_rd_sel = r_status;
      default:  w_rd_sel = '0;
    endcase
    w_rd_data = '0;
    w_rd_data[NUM_PINS-1:0] = w_rd_sel;
  end

  assign bus.rd_data_o = w_rd_data;
  assign gpio_o        = OUT_INVERT ? ~r_out : r_out;
  assign gpio_oe       = r_dir;
  assign irq_o         = |r_status;

endmodule

// File: tb/tb_gpio_irq.sv
// tb/tb_gpio_irq.sv - randomized and directed bench for gpio_irq against a pin-history reference model
module tb_gpio_irq;
  localparam int NP = 8;
  localparam int SS = 2;

  logic          sys_clk = 1'b0;
  logic          sys_reset;
  logic [NP-1:0] gpio_i;
  logic [NP-1:0] gpio_o;
  logic [NP-1:0] gpio_oe;
  logic          irq_o;

  gpio_irq_if bus_if ();

  gpio_irq #(.NUM_PINS(NP), .SYNC_STAGES(SS), .OUT_INVERT(1'b1)) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .bus      (bus_if),
    .gpio_i   (gpio_i),
    .gpio_o   (gpio_o),
    .gpio_oe  (gpio_oe),
    .irq_o    (irq_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  logic [NP-1:0] m_dir, m_out, m_rise, m_fall, m_status;
  logic [4:0]    m_rd_addr;
  // Pin values sampled at each clock edge since reset, oldest first.
  logic [NP-1:0] hist[$];

  function automatic logic [NP-1:0] m_in();
    return hist[hist.size() - SS];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [NP-1:0] v;
    case (a)
      5'h00:   v = m_dir;
      5'h04:   v = m_out;
      5'h08:   v = m_in();
      5'h0C:   v = m_rise;
      5'h10:   v = m_fall;
      5'h14:   v = m_status;
      default: v = '0;
    endcase
    return {24'h0, v};
  endfunction

  task automatic model_reset();
    m_dir = '0; m_out = '0; m_rise = '0; m_fall = '0; m_status = '0; m_rd_addr = '0;
    hist.delete();
    for (int i = 0; i < SS + 1; i++) hist.push_back('0);
  endtask

  task automatic model_edge();
    logic [NP-1:0] nw, od, ev, wd, clr;
    logic [4:0]    wa;
    hist.push_back(gpio_i);
    if (hist.size() > SS + 2) void'(hist.pop_front());
    nw  = hist[hist.size() - 1 - SS];
    od  = hist[hist.size() - 2 - SS];
    ev  = (nw & ~od & m_rise) | (~nw & od & m_fall);
    wa  = bus_if.wr_addr_i[4:0];
    wd  = bus_if.wr_data_i[NP-1:0];
    clr = (bus_if.wr_en_i && wa == 5'h14) ? wd : '0;
    m_status = (m_status & ~clr) | ev;
    if (bus_if.wr_en_i) begin
      case (wa)
        5'h00: m_dir  = wd;
        5'h04: m_out  = wd;
        5'h0C: m_rise = wd;
        5'h10: m_fall = wd;
        5'h18: m_out  = m_out | wd;
        5'h1C: m_out  = m_out & ~wd;
        default: ;
      endcase
    end
    m_rd_addr = bus_if.rd_addr_i[4:0];
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.wr_en_i   = 1'b1;
    bus_if.wr_addr_i = a;
    bus_if.wr_data_i = d;
    step();
    bus_if.wr_en_i   = 1'b0;
  endtask

  task automatic test_reset();
    if (bus_if.rd_data_o !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=%h", bus_if.rd_data_o, 32'h0); end
    checks++;
    if (gpio_o !== 8'hFF) begin failures++; $display("FAIL reset_gpio_o got=%h exp=%h", gpio_o, 8'hFF); end
    checks++;
    if (gpio_oe !== 8'h00) begin failures++; $display("FAIL reset_gpio_oe got=%h exp=%h", gpio_oe, 8'h00); end
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    checks++;
    for (int i = 0; i < 8; i++) begin
      bus_if.rd_addr_i = 32'(i * 4);
      step();
      if (bus_if.rd_data_o !== 32'h0) begin
        failures++; $display("FAIL reset_read_%0h got=%h exp=%h", i * 4, bus_if.rd_data_o, 32'h0);
      end
      checks++;
    end
  endtask

  task automatic test_out_setclr();
    bus_if.rd_addr_i = 32'h04;
    bus_write(32'h00, 32'hFF);
    bus_write(32'h04, 32'h0F);
    bus_write(32'h18, 32'h30);
    bus_write(32'h1C, 32'h03);
    if (bus_if.rd_data_o !== 32'h3C) begin failures++; $display("FAIL out_setclr got=%h exp=%h", bus_if.rd_data_o, 32'h3C); end
    checks++;
    if (gpio_o !== 8'hC3) begin failures++; $display("FAIL out_gpio_o got=%h exp=%h", gpio_o, 8'hC3); end
    checks++;
    if (gpio_oe !== 8'hFF) begin failures++; $display("FAIL out_gpio_oe got=%h exp=%h", gpio_oe, 8'hFF); end
    checks++;
    bus_write(32'h04, 32'hFFFF_FFFF);
    if (bus_if.rd_data_o !== 32'h0000_00FF) begin failures++; $display("FAIL out_wide got=%h exp=%h", bus_if.rd_data_o, 32'hFF); end
    checks++;
  endtask

  task automatic test_rise();
    bus_write(32'h10, 32'h0);
    bus_write(32'h0C, 32'h1);
    bus_if.rd_addr_i = 32'h08;
    step();
    gpio_i = gpio_i | 8'h03;
    step();
    if (irq_o !== 1'b0 || bus_if.rd_data_o[0] !== 1'b0) begin
      failures++; $display("FAIL rise_k irq=%b in0=%b exp irq=0 in0=0", irq_o, bus_if.rd_data_o[0]);
    end
    checks++;
    step();
    if (bus_if.rd_data_o !== 32'h3 || irq_o !== 1'b0) begin
      failures++; $display("FAIL rise_k1 in=%h irq=%b exp in=3 irq=0", bus_if.rd_data_o, irq_o);
    end
    checks++;
    step();
    if (irq_o !== 1'b1) begin failures++; $display("FAIL rise_k2_irq got=%b exp=1", irq_o); end
    checks++;
    bus_if.rd_addr_i = 32'h14;
    step();
    if (bus_if.rd_data_o !== 32'h1) begin failures++; $display("FAIL rise_status got=%h exp=%h", bus_if.rd_data_o, 32'h1); end
    checks++;
    bus_write(32'h14, 32'h1);
    if (irq_o !== 1'b0 || bus_if.rd_data_o !== 32'h0) begin
      failures++; $display("FAIL rise_w1c irq=%b status=%h exp irq=0 status=0", irq_o, bus_if.rd_data_o);
    end
    checks++;
  endtask

  task automatic test_fall_w1c();
    bus_write(32'h0C, 32'h0);
    gpio_i[2] = 1'b1;
    repeat (4) step();
    bus_write(32'h10, 32'h4);
    bus_if.rd_addr_i = 32'h14;
    gpio_i[2] = 1'b0;
    step(); step();
    if (irq_o !== 1'b0) begin failures++; $display("FAIL fall_early_irq got=%b exp=0", irq_o); end
    checks++;
    step();
    if (bus_if.rd_data_o !== 32'h4 || irq_o !== 1'b1) begin
      failures++; $display("FAIL fall_first status=%h irq=%b exp status=4 irq=1", bus_if.rd_data_o, irq_o);
    end
    checks++;
    bus_write(32'h14, 32'h4);
    if (bus_if.rd_data_o !== 32'h0 || irq_o !== 1'b0) begin
      failures++; $display("FAIL fall_clear1 status=%h irq=%b exp status=0 irq=0", bus_if.rd_data_o, irq_o);
    end
    checks++;
    gpio_i[2] = 1'b1;
    repeat (4) step();
    gpio_i[2] = 1'b0;
    step(); step();
    bus_write(32'h14, 32'h4);
    if (bus_if.rd_data_o !== 32'h4 || irq_o !== 1'b1) begin
      failures++; $display("FAIL fall_set_wins status=%h irq=%b exp status=4 irq=1", bus_if.rd_data_o, irq_o);
    end
    checks++;
    bus_write(32'h14, 32'h4);
    if (bus_if.rd_data_o !== 32'h0 || irq_o !== 1'b0) begin
      failures++; $display("FAIL fall_clear2 status=%h irq=%b exp status=0 irq=0", bus_if.rd_data_o, irq_o);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    bus_write(32'h00, 32'h00);
    bus_write(32'h04, 32'hA5);
    bus_if.rd_addr_i = 32'h04;
    step();
    if (bus_if.rd_data_o !== 32'hA5) begin failures++; $display("FAIL b2b_out got=%h exp=%h", bus_if.rd_data_o, 32'hA5); end
    checks++;
    bus_if.rd_addr_i = 32'h08;
    step();
    if (bus_if.rd_data_o !== {24'h0, gpio_i} || bus_if.rd_data_o !== m_read(5'h08)) begin
      failures++; $display("FAIL b2b_in got=%h exp=%h", bus_if.rd_data_o, {24'h0, gpio_i});
    end
    checks++;
    if (gpio_o !== 8'h5A || gpio_oe !== 8'h00) begin
      failures++; $display("FAIL b2b_pins gpio_o=%h oe=%h exp gpio_o=5a oe=00", gpio_o, gpio_oe);
    end
    checks++;
    foreach (hist[i]) if (i < 0) checks++;
    for (int i = 0; i < 3; i++) begin
      bus_if.rd_addr_i = (i == 0) ? 32'h20 : (i == 1) ? 32'h18 : 32'h1C;
      step();
      if (bus_if.rd_data_o !== 32'h0) begin
        failures++; $display("FAIL b2b_zero_%0d got=%h exp=%h", i, bus_if.rd_data_o, 32'h0);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      bus_if.wr_en_i = 1'($urandom_range(0, 1));
      a = $urandom();
      a[4:0] = 5'($urandom_range(0, 7) * 4);
      bus_if.wr_addr_i = a;
      bus_if.wr_data_i = $urandom();
      a = $urandom();
      a[4:0] = 5'($urandom_range(0, 7) * 4);
      bus_if.rd_addr_i = a;
      if ($urandom_range(0, 2) == 0) gpio_i = gpio_i ^ 8'($urandom());
      step();
      if (bus_if.rd_data_o !== m_read(m_rd_addr)) begin
        failures++; $display("FAIL rand_rd n=%0d addr=%h got=%h exp=%h", n, m_rd_addr, bus_if.rd_data_o, m_read(m_rd_addr));
      end
      checks++;
      if (gpio_o !== ~m_out) begin failures++; $display("FAIL rand_gpio_o n=%0d got=%h exp=%h", n, gpio_o, ~m_out); end
      checks++;
      if (gpio_oe !== m_dir) begin failures++; $display("FAIL rand_gpio_oe n=%0d got=%h exp=%h", n, gpio_oe, m_dir); end
      checks++;
      if (irq_o !== (|m_status)) begin failures++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq_o, |m_status); end
      checks++;
    end
    bus_if.wr_en_i = 1'b0;
  endtask

  task automatic test_async_reset();
    bus_write(32'h00, 32'hF0);
    bus_write(32'h10, 32'h0);
    bus_write(32'h0C, 32'h0);
    gpio_i = '0;
    repeat (4) step();
    bus_write(32'h0C, 32'hFF);
    bus_if.rd_addr_i = 32'h14;
    gpio_i = 8'hFF;
    repeat (3) step();
    if (bus_if.rd_data_o !== 32'hFF || irq_o !== 1'b1) begin
      failures++; $display("FAIL ares_pre status=%h irq=%b exp status=ff irq=1", bus_if.rd_data_o, irq_o);
    end
    checks++;
    #2 sys_reset = 1'b1;
    #1;
    if (irq_o !== 1'b0 || bus_if.rd_data_o !== 32'h0) begin
      failures++; $display("FAIL ares_async irq=%b rd=%h exp irq=0 rd=0", irq_o, bus_if.rd_data_o);
    end
    checks++;
    if (gpio_oe !== 8'h00 || gpio_o !== 8'hFF) begin
      failures++; $display("FAIL ares_pins oe=%h gpio_o=%h exp oe=00 gpio_o=ff", gpio_oe, gpio_o);
    end
    checks++;
    model_reset();
    @(negedge sys_clk);
    sys_reset = 1'b0;
    repeat (4) step();
    if (bus_if.rd_data_o !== 32'h0 || irq_o !== 1'b0) begin
      failures++; $display("FAIL ares_status_lost status=%h irq=%b exp status=0 irq=0", bus_if.rd_data_o, irq_o);
    end
    checks++;
    bus_if.rd_addr_i = 32'h08;
    step();
    if (bus_if.rd_data_o !== 32'hFF || bus_if.rd_data_o !== m_read(m_rd_addr)) begin
      failures++; $display("FAIL ares_in got=%h exp=%h", bus_if.rd_data_o, 32'hFF);
    end
    checks++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_reset        = 1'b1;
    bus_if.wr_en_i   = 1'b0;
    bus_if.wr_addr_i = '0;
    bus_if.wr_data_i = '0;
    bus_if.rd_addr_i = '0;
    gpio_i           = '0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_reset = 1'b0;
    test_reset();
    test_out_setclr();
    test_rise();
    test_fall_w1c();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
